// File: rtl/covariance_kernel_sequencer.sv
// Top-level ap_ctrl_hs sequencer for the covariance kernel.
// Runs column mean (s0), centering (s1), then one covariance-row pass (s2) per row.
//
// Ports:
//   ap_clk, ap_rst_n          clock, async active-low reset
//   ap_start/done/ready/idle  host block-level handshake
//   sN_start/ready/done       per-child handshake, N = 0..2
//   s2_row                    row index for the current stage-2 pass
//   cyc_s0/s1/s2              saturating cycles-in-stage counters
module covariance_kernel_sequencer #(
    parameter int OUTER_TRIP = 32,
    parameter int ROW_W      = 8,
    parameter int CNT_W      = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_ready,
    output logic             ap_idle,
    output logic             s0_start,
    input  logic             s0_ready,
    input  logic             s0_done,
    output logic             s1_start,
    input  logic             s1_ready,
    input  logic             s1_done,
    output logic             s2_start,
    input  logic             s2_ready,
    input  logic             s2_done,
    output logic [ROW_W-1:0] s2_row,
    output logic [CNT_W-1:0] cyc_s0,
    output logic [CNT_W-1:0] cyc_s1,
    output logic [CNT_W-1:0] cyc_s2
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_S0   = 3'd1;
    localparam logic [2:0] ST_S1   = 3'd2;
    localparam logic [2:0] ST_S2   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUTER_TRIP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [2:0]       state_q, state_d;
    logic             pend_q, pend_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] cyc_s0_q, cyc_s0_d;
    logic [CNT_W-1:0] cyc_s1_q, cyc_s1_d;
    logic [CNT_W-1:0] cyc_s2_q, cyc_s2_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        row_d    = row_q;
        cyc_s0_d = cyc_s0_q;
        cyc_s1_d = cyc_s1_q;
        cyc_s2_d = cyc_s2_q;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    state_d  = ST_S0;
                    pend_d   = 1'b1;
                    row_d    = '0;
                    cyc_s0_d = '0;
                    cyc_s1_d = '0;
                    cyc_s2_d = '0;
                end
            end
            ST_S0: begin
                cyc_s0_d = sat_inc(cyc_s0_q);
                // done implies acceptance, so it wins over ready
                if (s0_done) begin
                    state_d = ST_S1;
                    pend_d  = 1'b1;
                end else if (s0_ready) begin
                    pend_d = 1'b0;
                end
            end
            ST_S1: begin
                cyc_s1_d = sat_inc(cyc_s1_q);
                if (s1_done) begin
                    state_d = ST_S2;
                    pend_d  = 1'b1;
                end else if (s1_ready) begin
                    pend_d = 1'b0;
                end
            end
            ST_S2: begin
                cyc_s2_d = sat_inc(cyc_s2_q);
                if (s2_done) begin
                    if (row_q == LAST_ROW) begin
                        state_d = ST_DONE;
                        pend_d  = 1'b0;
                    end else begin
                        // re-arm beats a same-cycle ready for the old row
                        row_d  = row_q + ROW_W'(1);
                        pend_d = 1'b1;
                    end
                end else if (s2_ready) begin
                    pend_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= ST_IDLE;
            pend_q   <= 1'b0;
            row_q    <= '0;
            cyc_s0_q <= '0;
            cyc_s1_q <= '0;
            cyc_s2_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            row_q    <= row_d;
            cyc_s0_q <= cyc_s0_d;
            cyc_s1_q <= cyc_s1_d;
            cyc_s2_q <= cyc_s2_d;
        end
    end

    // All outputs decode from flops, so an async reset reaches them at once.
    assign ap_idle  = (state_q == ST_IDLE);
    assign ap_done  = (state_q == ST_DONE);
    assign ap_ready = (state_q == ST_DONE);
    assign s0_start = pend_q && (state_q == ST_S0);
    assign s1_start = pend_q && (state_q == ST_S1);
    assign s2_start = pend_q && (state_q == ST_S2);
    assign s2_row   = row_q;
    assign cyc_s0   = cyc_s0_q;
    assign cyc_s1   = cyc_s1_q;
    assign cyc_s2   = cyc_s2_q;

endmodule

// File: tb/tb_covariance_kernel_sequencer.sv
// Bench for covariance_kernel_sequencer.
// Instance a: 4 rows with a child responder; instance b: 1 row, 4-bit counters.
module tb_covariance_kernel_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    int n_assert = 0;
    int n_fail   = 0;

    // instance a
    logic       a_start;
    wire        a_done, a_ready, a_idle;
    wire  [2:0] a_st;
    logic [2:0] a_rdy, a_dn, a_sp;
    wire  [7:0] a_row;
    wire [31:0] a_c0, a_c1, a_c2;

    // instance b
    logic       b_start;
    wire        b_done, b_ready, b_idle;
    wire  [2:0] b_st;
    logic [2:0] b_rdy, b_dn;
    wire  [7:0] b_row;
    wire  [3:0] b_c0, b_c1, b_c2;

    covariance_kernel_sequencer #(
        .OUTER_TRIP(4), .ROW_W(8), .CNT_W(32)
    ) dut_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(a_start),
        .ap_done(a_done), .ap_ready(a_ready), .ap_idle(a_idle),
        .s0_start(a_st[0]), .s0_ready(a_rdy[0]), .s0_done(a_dn[0] | a_sp[0]),
        .s1_start(a_st[1]), .s1_ready(a_rdy[1]), .s1_done(a_dn[1] | a_sp[1]),
        .s2_start(a_st[2]), .s2_ready(a_rdy[2]), .s2_done(a_dn[2] | a_sp[2]),
        .s2_row(a_row), .cyc_s0(a_c0), .cyc_s1(a_c1), .cyc_s2(a_c2)
    );

    covariance_kernel_sequencer #(
        .OUTER_TRIP(1), .ROW_W(8), .CNT_W(4)
    ) dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(b_start),
        .ap_done(b_done), .ap_ready(b_ready), .ap_idle(b_idle),
        .s0_start(b_st[0]), .s0_ready(b_rdy[0]), .s0_done(b_dn[0]),
        .s1_start(b_st[1]), .s1_ready(b_rdy[1]), .s1_done(b_dn[1]),
        .s2_start(b_st[2]), .s2_ready(b_rdy[2]), .s2_done(b_dn[2]),
        .s2_row(b_row), .cyc_s0(b_c0), .cyc_s1(b_c1), .cyc_s2(b_c2)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_nonempty(input string tag, input int sz);
        n_assert++;
        assert (sz != 0) else begin
            n_fail++;
            $error("FAIL %s: observed empty queue expected an entry", tag);
        end
    endtask

    // scoreboard
    typedef struct {
        int dc;
        int c0;
        int c1;
        int c2;
    } res_t;

    res_t q_res[$];
    int   q_ord[$];
    int   q_row[$];
    int   q_len[$];
    int   n_done = 0;

    task automatic push_run(input int k, input int rd, input int dn);
        res_t r;
        int   len;
        len = ((rd < dn) ? rd : dn) + 1;
        q_ord.push_back(0);
        q_ord.push_back(1);
        for (int i = 0; i < 4; i++) begin
            q_ord.push_back(2);
            q_row.push_back(i);
        end
        for (int i = 0; i < 6; i++) q_len.push_back(len);
        r.dc = k + 1 + 6 * (dn + 1);
        r.c0 = dn + 1;
        r.c1 = dn + 1;
        r.c2 = 4 * (dn + 1);
        q_res.push_back(r);
    endtask

    // child responder for instance a: ready/done at fixed ages after start
    int rdy_dly = 3;
    int dn_dly  = 3;

    initial begin
        int busy = 0;
        int idx  = 0;
        int age  = 0;
        int slen = 0;
        a_rdy = '0;
        a_dn  = '0;
        forever begin
            @(negedge clk);
            a_rdy = '0;
            a_dn  = '0;
            if (!rst_n) begin
                busy = 0;
            end else begin
                if (busy == 0) begin
                    for (int i = 0; i < 3; i++) begin
                        if (busy == 0 && a_st[i]) begin
                            busy = 1;
                            idx  = i;
                            age  = 0;
                            slen = 0;
                            chk_nonempty("order_q", q_ord.size());
                            if (q_ord.size() != 0)
                                chk("stage_order", i, q_ord.pop_front());
                            if (i == 2) begin
                                chk_nonempty("row_q", q_row.size());
                                if (q_row.size() != 0)
                                    chk("s2_row", a_row, q_row.pop_front());
                            end
                        end
                    end
                end
                if (busy != 0) begin
                    if (a_st[idx]) slen++;
                    if (age == rdy_dly) a_rdy[idx] = 1'b1;
                    if (age == dn_dly) begin
                        a_dn[idx] = 1'b1;
                        busy = 0;
                        chk_nonempty("len_q", q_len.size());
                        if (q_len.size() != 0)
                            chk("start_len", slen, q_len.pop_front());
                    end
                    age++;
                end
            end
        end
    end

    // completion monitor for instance a
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rst_n && a_done) begin
                n_done++;
                chk("a_ready_eq_done", a_ready, 1);
                chk_nonempty("res_q", q_res.size());
                if (q_res.size() != 0) begin
                    r = q_res.pop_front();
                    chk("done_cycle", cyc, r.dc);
                    chk("cyc_s0", a_c0, r.c0);
                    chk("cyc_s1", a_c1, r.c1);
                    chk("cyc_s2", a_c2, r.c2);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic start_a(input int rd, input int dn);
        int n = 0;
        while (!a_idle && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("a_idle_before_start", a_idle, 1);
        rdy_dly = rd;
        dn_dly  = dn;
        push_run(cyc, rd, dn);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_a_done(input int lim);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_done && n < lim);
        chk("a_done_seen", a_done, 1);
    endtask

    initial begin
        int d;
        int nd;
        int n;
        rst_n   = 1'b0;
        a_start = 1'b0;
        a_sp    = '0;
        b_start = 1'b0;
        b_rdy   = '0;
        b_dn    = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_a_idle", a_idle, 1);
        chk("rst_a_done", {a_done, a_ready}, 0);
        chk("rst_a_start", a_st, 0);
        chk("rst_a_row", a_row, 0);
        chk("rst_a_cnt", {a_c0, a_c1, a_c2}, 0);
        chk("rst_b_idle", b_idle, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // ready+done 3 cycles after start
        start_a(3, 3);
        wait_a_done(100);
        @(negedge clk);
        chk("t1_idle_after", a_idle, 1);
        chk("t1_no_start", a_st, 0);
        @(negedge clk);
        chk("t1_hold_s2", a_c2, 16);

        // zero-latency children over four rows
        start_a(0, 0);
        wait_a_done(100);
        @(negedge clk);

        // ready at 2, done at 10
        start_a(2, 10);
        wait_a_done(200);
        @(negedge clk);

        // ap_start held through DONE
        rdy_dly = 3;
        dn_dly  = 3;
        push_run(cyc, 3, 3);
        a_start = 1'b1;
        wait_a_done(100);
        d = cyc;
        push_run(d + 1, 3, 3);
        @(negedge clk);
        chk("t4_idle_one", a_idle, 1);
        chk("t4_idle_nostart", a_st, 0);
        @(negedge clk);
        a_start = 1'b0;
        chk("t4_idle_gone", a_idle, 0);
        chk("t4_s0_restart", a_st, 3'b001);
        chk("t4_cnt_clear", {a_c0, a_c2}, 0);
        wait_a_done(100);
        @(negedge clk);

        // async reset mid stage 2, row 2
        start_a(3, 3);
        n = 0;
        while (a_row != 8'd2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_row2", a_row, 2);
        nd = n_done;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_idle", a_idle, 1);
        chk("t5_start", a_st, 0);
        chk("t5_row", a_row, 0);
        chk("t5_cnt", {a_c0, a_c1, a_c2}, 0);
        chk("t5_done", a_done, 0);
        q_res.delete();
        q_ord.delete();
        q_row.delete();
        q_len.delete();
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_no_done", n_done, nd);
        start_a(3, 3);
        wait_a_done(100);
        @(negedge clk);

        // spurious s2_done in IDLE, spurious s1_done in S0
        a_sp = 3'b100;
        repeat (3) @(negedge clk);
        chk("t6_idle_hold", a_idle, 1);
        chk("t6_idle_nostart", a_st, 0);
        a_sp = '0;
        start_a(3, 8);
        a_sp = 3'b010;
        repeat (3) @(negedge clk);
        a_sp = '0;
        wait_a_done(100);
        @(negedge clk);

        // instance b: zero latency, one row, done held high in IDLE
        b_rdy = 3'b111;
        b_dn  = 3'b111;
        repeat (2) @(negedge clk);
        chk("b_idle_ignore", {b_idle, b_st}, 4'b1000);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("b_t2_s0", b_st, 3'b001);
        @(negedge clk);
        chk("b_t2_s1", b_st, 3'b010);
        @(negedge clk);
        chk("b_t2_s2", b_st, 3'b100);
        @(negedge clk);
        chk("b_t2_done", {b_done, b_ready, b_st}, 5'b11000);
        chk("b_t2_cnt", {b_c0, b_c1, b_c2}, 12'h111);
        @(negedge clk);
        chk("b_t2_idle", b_idle, 1);

        // instance b: 20-cycle s0 with 4-bit counters, s1_done held meanwhile
        b_rdy = '0;
        b_dn  = 3'b010;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        repeat (19) @(negedge clk);
        chk("b_t6_still_s0", b_st, 3'b001);
        chk("b_t6_sat", b_c0, 15);
        b_dn = 3'b001;
        @(negedge clk);
        chk("b_t6_s1", b_st, 3'b010);
        b_dn = 3'b010;
        @(negedge clk);
        chk("b_t6_s2", b_st, 3'b100);
        b_dn = 3'b100;
        @(negedge clk);
        b_dn = '0;
        chk("b_t6_done", b_done, 1);
        chk("b_t6_cnt", {b_c0, b_c1, b_c2}, 12'hF11);

        repeat (3) @(negedge clk);
        chk("sb_empty", q_res.size() + q_ord.size() + q_row.size() + q_len.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
